rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.
- Supersedes the fixed 2:1 select muxes wherever several requesters share one 32-bit path in the multicycle CPU, e.g. instruction fetch and load/store sharing the memory address port.
- Selection is either round-robin arbitration or a forced fixed select, which reproduces classic mux behaviour.
- The output is held in a one-entry register, giving one cycle of latency and full throughput.

Parameters:
- WIDTH, 32: data width per channel, in bits.
- N, 2: number of input channels; legal range 2..8.
- SEL_W, 3: width of the select/index fields. Must satisfy SEL_W >= clog2(N); fixed at 3 for the legal range.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  channel i is presenting a word.
- in_ready  out  N  channel i's word is accepted this cycle (combinational).
- force_en  in  1  1 = fixed-select mode; 0 = round-robin mode.
- force_sel  in  SEL_W  channel forced when force_en = 1.
- out_data  out  WIDTH  registered output word.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge):
  - out_valid = 0, out_data = 0, out_sel = 0, round-robin pointer ptr = 0.
  - in_ready is all-zero while rst = 1.
- Output register capacity:
  - can_load = !out_valid | out_ready.
  - An output transfer occurs when out_valid & out_ready.
- Eligibility:
  - Round-robin mode: elig = in_valid.
  - Forced mode: elig = in_valid & onehot(force_sel).
  - If force_sel >= N, elig = 0: no grant, no error flag.
- Grant:
  - Round-robin mode: the first eligible channel found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - Forced mode: the only eligible channel.
  - At most one grant bit per cycle.
- Handshake:
  - in_ready[i] = grant[i] & can_load & !rst.
  - A channel transfers when in_valid[i] & in_ready[i].
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_valid must not depend on in_ready.
- Load (on an input transfer from channel g, at the clock edge):
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - Latency: one cycle from accept to out_valid.
- Drain: on an output transfer with no input transfer in the same cycle, out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge and out_valid stays 1. This gives full throughput of one word per cycle.
- Stall: while out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid are stable and every in_ready = 0.
- Pointer update:
  - Only on an input transfer in round-robin mode: ptr <= (g == N-1) ? 0 : g+1.
  - In forced mode, or with no transfer, ptr holds its value.
  - Switching modes never resets ptr.
- Fairness: with every channel continuously valid and out_ready = 1 in round-robin mode, grants cycle 0, 1, ..., N-1, 0, ... with no gaps.
- Mid-operation reset: an output word is discarded (out_valid = 0 on the next cycle) regardless of out_ready. No input is accepted in the reset cycle.
- All state is updated on the rising edge of clk only. There are no latches and no asynchronous paths.

Test Plan:
- Reset flush: load 0xDEADBEEF with out_ready = 0, then assert rst for 1 cycle. Required: out_valid = 0, out_data = 0, out_sel = 0, and in_ready = 0 during rst.
- Round-robin, N = 4: all in_valid = 1, in_data[i] = 0x100 + i, out_ready = 1. Required: out_sel sequence 0, 1, 2, 3, 0 and out_data 0x100, 0x101, 0x102, 0x103, 0x100, with out_valid = 1 every cycle from cycle 1 onward.
- Backpressure: out_ready = 0 for 3 cycles after the first load. Required: out_data stable and in_ready = 0000. After out_ready = 1, the next word loads in the same cycle the held word drains.
- Forced mode: force_en = 1, force_sel = 2, all in_valid = 1. Required: only in_ready[2] pulses and out_sel = 2 every word. Then force_sel = 5 with N = 4: no grant and out_valid falls to 0 after the drain.
- Pointer retention: in round-robin, grant channel 1, then run forced mode on channel 3 for 4 words, then return to round-robin with all valid. Required: the first round-robin grant is channel 2.
- Sparse requests: only in_valid[3] = 1, then only in_valid[0] = 1. Required: grants go to 3 then 0, each with 1-cycle latency, and ptr wraps to 0 after channel 3.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel, WIDTH-bit multiplexer with valid/ready handshakes.
// Picks one requester per cycle, either by round-robin arbitration or by a
// forced fixed select, and captures it into a one-entry output register.
// The output register gives one cycle of latency and one word per cycle.
module rr_mux_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 force_en,
    input  logic [SEL_W-1:0]     force_sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] ptr;
    logic             can_load;
    logic [N-1:0]     force_onehot;
    logic [N-1:0]     elig;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] grant_data;
    logic             in_xfer;

    // The register can take a new word when empty or when its word drains now.
    assign can_load = !out_valid || out_ready;

    // Eligible channels; a force_sel outside 0..N-1 matches nothing.
    always_comb begin
        force_onehot = '0;
        for (int i = 0; i < N; i++) begin
            force_onehot[i] = (force_sel == SEL_W'(i));
        end
        elig = force_en ? (in_valid & force_onehot) : in_valid;
    end

    // Round-robin scan from ptr upward, then wrap to the channels below ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_any && elig[i] && (SEL_W'(i) >= ptr)) begin
                grant_any = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_any && elig[i] && (SEL_W'(i) < ptr)) begin
                grant_any = 1'b1;
                grant_idx = SEL_W'(i);
            end
        end
    end

    // Expand the winning index into a one-hot grant and select its data word.
    always_comb begin
        grant      = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_any && (grant_idx == SEL_W'(i))) begin
                grant[i]   = 1'b1;
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = grant & {N{can_load && !rst}};
    assign in_xfer  = |(in_valid & in_ready);

    // Output register and round-robin pointer; pointer only moves on
    // round-robin transfers so forced bursts do not disturb fairness order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (in_xfer) begin
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                out_valid <= 1'b1;
                if (!force_en) begin
                    ptr <= (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed-vector bench for rr_mux_reg with N = 4, WIDTH = 32.
// Each scenario task drives inputs just after a rising edge and checks
// registered outputs one time unit after the following edge.
module tb_rr_mux_reg;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SEL_W = 3;

    logic                 clk;
    logic                 rst;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic                 force_en;
    logic [SEL_W-1:0]     force_sel;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks;
    int n_fail;

    rr_mux_reg #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] valid, input logic ready);
        in_valid  = valid;
        out_ready = ready;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        force_en  = 1'b0;
        force_sel = '0;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'h100 + i;
        apply_stimulus(4'b1111, 1'b0);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", out_data); end
        n_checks++; if (out_sel !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_sel: got %0d want 0", out_sel); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 0000", in_ready); end
        // Load a word that will be stuck in the register, then flush it.
        rst = 1'b0;
        in_data[0 +: WIDTH] = 32'hDEADBEEF;
        apply_stimulus(4'b0001, 1'b0);
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL flush_accept: got %b want 0001", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL flush_load: got v=%0b d=%h want v=1 d=deadbeef", out_valid, out_data); end
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL flush_in_ready_rst: got %b want 0000", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_clear: got v=%0b d=%h s=%0d want 0/0/0", out_valid, out_data, out_sel); end
        rst = 1'b0;
        in_data[0 +: WIDTH] = 32'h100;
        apply_stimulus(4'b0000, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_ready;
        apply_stimulus(4'b1111, 1'b1);
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL rr_first_ready: got %b want 0001", in_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_ready = 4'b0001 << ((k + 1) % 4);
            n_checks++; if (out_valid !== 1'b1 || out_sel !== SEL_W'(k % 4) || out_data !== 32'h100 + (k % 4)) begin
                n_fail++; $display("[TB] FAIL rr_word%0d: got v=%0b s=%0d d=%h want v=1 s=%0d d=%h", k, out_valid, out_sel, out_data, k % 4, 32'h100 + (k % 4));
            end
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rr_ready%0d: got %b want %b", k, in_ready, exp_ready); end
        end
        apply_stimulus(4'b0000, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h100 || out_sel !== 3'd0) begin n_fail++; $display("[TB] FAIL rr_drain: got v=%0b d=%h s=%0d want 0/100/0", out_valid, out_data, out_sel); end
    endtask

    task automatic test_backpressure();
        // Pointer is at 1 after the round-robin run.
        apply_stimulus(4'b1111, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h101) begin n_fail++; $display("[TB] FAIL bp_first: got v=%0b d=%h want 1/101", out_valid, out_data); end
        apply_stimulus(4'b1111, 1'b0);
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_ready_stall: got %b want 0000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h101 || out_sel !== 3'd1 || in_ready !== 4'b0000) begin
                n_fail++; $display("[TB] FAIL bp_hold%0d: got v=%0b d=%h s=%0d r=%b want 1/101/1/0000", k, out_valid, out_data, out_sel, in_ready);
            end
        end
        apply_stimulus(4'b1111, 1'b1);
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b want 0100", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h102 || out_sel !== 3'd2) begin n_fail++; $display("[TB] FAIL bp_swap: got v=%0b d=%h s=%0d want 1/102/2", out_valid, out_data, out_sel); end
        apply_stimulus(4'b0000, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_forced();
        // Pointer is at 3; forced mode must not move it.
        force_en  = 1'b1;
        force_sel = 3'd2;
        apply_stimulus(4'b1111, 1'b1);
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL force_ready0: got %b want 0100", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 32'h102 || in_ready !== 4'b0100) begin
                n_fail++; $display("[TB] FAIL force_word%0d: got v=%0b s=%0d d=%h r=%b want 1/2/102/0100", k, out_valid, out_sel, out_data, in_ready);
            end
        end
        force_sel = 3'd5;
        #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL force_oob_ready: got %b want 0000", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_sel !== 3'd2) begin n_fail++; $display("[TB] FAIL force_oob_drain: got v=%0b s=%0d want 0/2", out_valid, out_sel); end
    endtask

    task automatic test_pointer_retention();
        force_en = 1'b0;
        apply_stimulus(4'b0010, 1'b1);
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL ret_ready1: got %b want 0010", in_ready); end
        tick();
        n_checks++; if (out_sel !== 3'd1 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ret_grant1: got s=%0d v=%0b want 1/1", out_sel, out_valid); end
        force_en  = 1'b1;
        force_sel = 3'd3;
        apply_stimulus(4'b1111, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (out_sel !== 3'd3 || out_data !== 32'h103) begin n_fail++; $display("[TB] FAIL ret_force%0d: got s=%0d d=%h want 3/103", k, out_sel, out_data); end
        end
        force_en = 1'b0;
        #1;
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL ret_resume_ready: got %b want 0100", in_ready); end
        tick();
        n_checks++; if (out_sel !== 3'd2 || out_data !== 32'h102) begin n_fail++; $display("[TB] FAIL ret_resume: got s=%0d d=%h want 2/102", out_sel, out_data); end
        apply_stimulus(4'b0000, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ret_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_sparse();
        // Pointer is at 3.
        apply_stimulus(4'b1000, 1'b1);
        n_checks++; if (in_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL sparse_ready3: got %b want 1000", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 32'h103) begin n_fail++; $display("[TB] FAIL sparse_grant3: got v=%0b s=%0d d=%h want 1/3/103", out_valid, out_sel, out_data); end
        // With all channels requesting, the wrapped pointer must favour channel 0.
        apply_stimulus(4'b1111, 1'b1);
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL sparse_wrap: got %b want 0001", in_ready); end
        apply_stimulus(4'b0001, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 32'h100) begin n_fail++; $display("[TB] FAIL sparse_grant0: got v=%0b s=%0d d=%h want 1/0/100", out_valid, out_sel, out_data); end
        apply_stimulus(4'b0000, 1'b1);
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sparse_drain: got %0b want 0", out_valid); end
    endtask

    // Scenario sequence.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_sel = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_forced();
        test_pointer_retention();
        test_sparse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
